// File: rtl/cpu_defs.sv
// Shared definitions for the control_unit instruction format.
// Instruction word layout: {op[8:6], rx[5:3], ry[2:0]}.
// Provides opcode constants, step-count constants, the instruction width,
// the idle NOP word and a small helper that packs instruction fields.
package cpu_defs;

    localparam int IW = 9;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_NOP = 3'b011;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_REP = 3'b111;

    localparam logic [1:0] STEP0 = 2'b00;
    localparam logic [1:0] STEP1 = 2'b01;
    localparam logic [1:0] STEP2 = 2'b10;
    localparam logic [1:0] STEP3 = 2'b11;

    // Opcode 011 is never decoded by control_unit, so this word is inert.
    localparam logic [IW-1:0] NOP_INSTR = {OP_NOP, 3'b000, 3'b000};

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
    } instr_t;

    function automatic logic [IW-1:0] make_instr(input logic [2:0] op,
                                                 input logic [2:0] rx,
                                                 input logic [2:0] ry);
        instr_t w;
        w.op = op;
        w.rx = rx;
        w.ry = ry;
        return w;
    endfunction

endpackage

// File: rtl/instr_sequencer_sync_fifo.sv
// sync_fifo: single-clock instruction FIFO with registered read data.
// Ports:
//   clock   in   rising-edge clock
//   resetn  in   synchronous active-low reset (pointers and level cleared)
//   push    in   write din (ignored while full)
//   pop     in   load head into dout (ignored while empty)
//   din     in   [IW-1:0] write data
//   dout    out  [IW-1:0] registered head captured on the last pop
//   level   out  [$clog2(DEPTH):0] occupancy
//   empty   out  level == 0
//   full    out  level == DEPTH
// There is no fall-through: a word written this cycle is only visible to a
// pop from the next cycle on, and a full FIFO refuses a push even if a pop
// frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int IW    = 9
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [IW-1:0]            din,
    output logic [IW-1:0]            dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [IW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [IW-1:0] dout_r;
    logic          do_push_s;
    logic          do_pop_s;
    logic          empty_s;
    logic          full_s;

    assign empty_s   = (level_r == LW'(0));
    assign full_s    = (level_r == LW'(DEPTH));
    assign do_push_s = push && !full_s;
    assign do_pop_s  = pop && !empty_s;

    // Storage array; not reset because the pointers define which entries are live.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
            dout_r   <= IW'(0);
        end else begin
            // DEPTH is a power of two, so natural overflow wraps the pointers.
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                dout_r   <= mem_r[rd_ptr_r];
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    assign dout  = dout_r;
    assign level = level_r;
    assign empty = empty_s;
    assign full  = full_s;

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: buffers instructions from the program loader and issues
// each one to control_unit for four steps (count 00,01,10,11).
// Ports:
//   clock       in   rising-edge clock
//   resetn      in   synchronous active-low reset; abandons any instruction in flight
//   load_valid  in   loader offers load_data
//   load_data   in   [IW-1:0] instruction to enqueue
//   load_ready  out  !full; push happens on load_valid && load_ready
//   run         in   1: keep issuing; 0: stop at the next instruction boundary
//   instr       out  [IW-1:0] to control_unit.in; NOP while idle
//   count       out  [1:0] to control_unit.count; 00 while idle
//   busy        out  an instruction is mid-issue
//   instr_done  out  high during the step-11 cycle
//   level       out  FIFO occupancy
//   empty/full  out  FIFO flags
module instr_sequencer #(
    parameter int            DEPTH = 16,
    parameter int            IW    = cpu_defs::IW,
    parameter logic [IW-1:0] NOP   = cpu_defs::NOP_INSTR
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   load_valid,
    input  logic [IW-1:0]          load_data,
    output logic                   load_ready,
    input  logic                   run,
    output logic [IW-1:0]          instr,
    output logic [1:0]             count,
    output logic                   busy,
    output logic                   instr_done,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty,
    output logic                   full
);

    import cpu_defs::*;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]    state_r;
    logic [1:0]    count_r;
    logic          instr_done_r;
    logic          push_s;
    logic          pop_s;
    logic [IW-1:0] fifo_dout_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;

    assign push_s = load_valid && !fifo_full_s;

    sync_fifo #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_fifo (
        .clock  (clock),
        .resetn (resetn),
        .push   (push_s),
        .pop    (pop_s),
        .din    (load_data),
        .dout   (fifo_dout_s),
        .level  (level),
        .empty  (fifo_empty_s),
        .full   (fifo_full_s)
    );

    // Pop decision: only at an instruction boundary (idle, or the last step).
    always_comb begin
        pop_s = 1'b0;
        case (state_r)
            IDLE: begin
                pop_s = run && !fifo_empty_s;
            end
            ISSUE: begin
                if (count_r == STEP3) begin
                    pop_s = run && !fifo_empty_s;
                end else begin
                    pop_s = 1'b0;
                end
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Issue FSM and step counter.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r      <= IDLE;
            count_r      <= STEP0;
            instr_done_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    count_r      <= STEP0;
                    instr_done_r <= 1'b0;
                    if (pop_s) begin
                        state_r <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Registered so that the pulse lines up with the step-11 cycle.
                    instr_done_r <= (count_r == STEP2);
                    if (count_r == STEP3) begin
                        count_r <= STEP0;
                        if (!pop_s) begin
                            state_r <= IDLE;
                        end
                    end else begin
                        count_r <= count_r + 2'd1;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    count_r      <= STEP0;
                    instr_done_r <= 1'b0;
                end
            endcase
        end
    end

    // The FIFO's read register is the instruction register; it is only
    // shown while issuing, otherwise control_unit sees the inert NOP.
    // Both select inputs are flops, so no input reaches instr combinationally.
    assign instr      = (state_r == ISSUE) ? fifo_dout_s : NOP;
    assign count      = count_r;
    assign busy       = (state_r == ISSUE);
    assign instr_done = instr_done_r;
    assign load_ready = !fifo_full_s;
    assign empty      = fifo_empty_s;
    assign full       = fifo_full_s;

endmodule
